// File: rtl/dice_roll_button.sv
// Debounced roll-button front end: synchronises/debounces nButton and sequences Roll/Settled.
// Optional auto-stop after MAX_ROLL_CYCLES is compiled in with DICE_BUTTON_AUTOSTOP_EN.
module dice_roll_button #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_ROLL_CYCLES = 64,
  parameter int unsigned MAX_ROLL_CYCLES = 1024
) (
  input  logic Clock,
  input  logic Reset,
  input  logic nButton,
  output logic Pressed,
  output logic Roll,
  output logic Settled
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef DICE_BUTTON_AUTOSTOP_EN
  localparam int unsigned ROLL_LIMIT = MAX_ROLL_CYCLES - 1;
`else
  localparam int unsigned ROLL_LIMIT = MIN_ROLL_CYCLES - 1;
`endif
  localparam int unsigned RC_W = (ROLL_LIMIT < 1) ? 1 : $clog2(ROLL_LIMIT + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] MIN_M1  = RC_W'(MIN_ROLL_CYCLES - 1);
  localparam logic [RC_W-1:0] CNT_SAT = RC_W'(ROLL_LIMIT);
`ifdef DICE_BUTTON_AUTOSTOP_EN
  localparam logic [RC_W-1:0] MAX_M1  = RC_W'(MAX_ROLL_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES == 0 || MIN_ROLL_CYCLES == 0 ||
      MAX_ROLL_CYCLES <= MIN_ROLL_CYCLES) begin : g_bad_params
    $error("dice_roll_button: invalid parameter set");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROLLING  = 3'd1,
    HOLD_MIN = 3'd2,
    SETTLE   = 3'd3,
    WAIT_REL = 3'd4
  } state_e;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pressed_q, pressed_d;
  logic [RC_W-1:0] roll_cnt_q, roll_cnt_d;
  state_e          state_q, state_d;
  logic            roll_q, roll_d;
  logic            settled_q, settled_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_cnt_q   <= '0;
      pressed_q  <= 1'b0;
      roll_cnt_q <= '0;
      state_q    <= IDLE;
      roll_q     <= 1'b0;
      settled_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      pressed_q  <= pressed_d;
      roll_cnt_q <= roll_cnt_d;
      state_q    <= state_d;
      roll_q     <= roll_d;
      settled_q  <= settled_d;
    end
  end

  // Synchroniser and debounce; sync2_q is low while the button is pressed.
  always_comb begin
    sync1_d   = nButton;
    sync2_d   = sync1_q;
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (~sync2_q == pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      pressed_d = ~pressed_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Roll sequencing; release takes priority over auto-stop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pressed_q) state_d = ROLLING;
      end
      ROLLING: begin
        if (!pressed_q) begin
          state_d = (roll_cnt_q >= MIN_M1) ? SETTLE : HOLD_MIN;
        end
`ifdef DICE_BUTTON_AUTOSTOP_EN
        else if (roll_cnt_q == MAX_M1) begin
          state_d = SETTLE;
        end
`endif
      end
      HOLD_MIN: begin
        if (roll_cnt_q == MIN_M1) state_d = SETTLE;
      end
      SETTLE: begin
        state_d = pressed_q ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!pressed_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Roll length counter, saturating at the largest value it is compared against.
  always_comb begin
    roll_cnt_d = roll_cnt_q;
    if (state_q == IDLE && state_d == ROLLING) begin
      roll_cnt_d = '0;
    end else if ((state_q == ROLLING || state_q == HOLD_MIN) && roll_cnt_q != CNT_SAT) begin
      roll_cnt_d = roll_cnt_q + RC_W'(1);
    end
  end

  // Outputs registered from the next state so they line up with state_q.
  always_comb begin
    roll_d    = (state_d == ROLLING) || (state_d == HOLD_MIN);
    settled_d = (state_d == SETTLE);
  end

  assign Pressed = pressed_q;
  assign Roll    = roll_q;
  assign Settled = settled_q;

endmodule

// File: doc/dice_roll_button.md
# dice_roll_button

Debounced roll-button front end for the dice design, upstream of the dice control/random stage. It synchronises and debounces the raw, active-low push-button, then runs a roll state machine. The state machine drives `Roll`, a level the dice controller uses to keep cycling values, and `Settled`, a one-cycle strobe that marks the moment the displayed value is final. Rolls have a guaranteed minimum length and, optionally, a maximum length.

## Interface
- `DEBOUNCE_CYCLES`, 16, consecutive synchronised samples a new button level must hold before `Pressed` changes (≥1)
- `MIN_ROLL_CYCLES`, 64, minimum cycles `Roll` stays high per roll (≥1)
- `MAX_ROLL_CYCLES`, 1024, auto-stop length; used only with the macro (> `MIN_ROLL_CYCLES`)

Ports:
- `Clock`  in  1  system clock, all logic on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `nButton`  in  1  raw asynchronous button, low = pressed
- `Pressed`  out  1  debounced button level, high = pressed
- `Roll`  out  1  high while the dice must keep cycling
- `Settled`  out  1  one-cycle strobe on the first cycle after a roll ends

## Operation
- Synchroniser: 2 flops on `nButton`, reset value 1 (released).
- Debounce:
  - Counter clears whenever the synchronised level equals the current debounced state.
  - It increments while the two differ.
  - When it reaches `DEBOUNCE_CYCLES`, `Pressed` toggles and the counter clears.
- Roll counter:
  - Clears on entry to ROLLING.
  - Increments every cycle in ROLLING or HOLD_MIN.
  - Saturates; width is clog2 of the largest compared value + 1.
- FSM states, all registered:
  - IDLE: waits for `Pressed`. `Pressed`=1 → ROLLING.
  - ROLLING:
    - `Pressed`=0 and count ≥ `MIN_ROLL_CYCLES`−1 → SETTLE.
    - `Pressed`=0 and count below that → HOLD_MIN.
    - With the macro only: count = `MAX_ROLL_CYCLES`−1 and `Pressed`=1 → SETTLE.
    - If release and the max count coincide, the result is SETTLE, then IDLE.
  - HOLD_MIN: a new press is ignored. count = `MIN_ROLL_CYCLES`−1 → SETTLE.
  - SETTLE: one cycle. `Pressed`=0 → IDLE; `Pressed`=1 → WAIT_REL.
  - WAIT_REL: no roll. `Pressed`=0 → IDLE. A fresh press is required for the next roll.
- Outputs are registered:
  - `Roll` = state ∈ {ROLLING, HOLD_MIN}.
  - `Settled` = state is SETTLE.
- Reset values: `Pressed`=0, `Roll`=0, `Settled`=0, state IDLE, both counters 0.
- Reset mid-roll: at the next edge `Roll`=0 and no `Settled` strobe is generated.
- Button held through reset: it is detected as a new press after synchroniser plus debounce latency, and a roll starts.

## Timing
- Pin edge to `Pressed` change: 2 + `DEBOUNCE_CYCLES` cycles, given the level is stable.
- `Pressed` rise to `Roll` rise: 1 cycle.
- `Roll` high duration:
  - Lower bound is exactly `MIN_ROLL_CYCLES`.
  - Otherwise it lasts until 1 cycle after the debounced release.
  - With the macro, the upper bound is exactly `MAX_ROLL_CYCLES`.
- `Settled` is high exactly 1 cycle, on the first cycle `Roll` is 0 after a completed roll.
- No combinational path from any input to any output.

## Configuration
- `DICE_BUTTON_AUTOSTOP_EN` defined:
  - The MAX comparison and the WAIT_REL path after auto-stop are compiled in.
  - A held button ends the roll after `MAX_ROLL_CYCLES`.
- Not defined:
  - `MAX_ROLL_CYCLES` is unused.
  - The roll counter saturates at `MIN_ROLL_CYCLES`−1.
  - `Roll` stays high for as long as the button is held.
  - WAIT_REL is reached only via a re-press during HOLD_MIN, with the button still held at SETTLE.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `MIN_ROLL_CYCLES`=8, `MAX_ROLL_CYCLES`=32.
- Glitch rejection: `nButton` low for 3 cycles, then high → `Pressed`, `Roll` and `Settled` remain 0 throughout.
- Normal roll: `nButton` low for 20 cycles, then high →
  - `Pressed` rises 6 cycles after the fall.
  - `Roll` rises 1 cycle later.
  - `Roll` falls 7 cycles after the pin rises.
  - `Settled` is high for exactly that cycle.
- Short press: `nButton` low for 6 cycles →
  - `Roll` high for exactly 8 cycles.
  - Then a single `Settled` pulse.
  - A second press during HOLD_MIN does not extend the roll.
- Auto-stop, macro defined: `nButton` low for 100 cycles →
  - `Roll` high exactly 32 cycles, then a `Settled` pulse.
  - `Roll` stays 0 until release and a new debounced press.
- Macro undefined, same stimulus → `Roll` high until 7 cycles after release, then `Settled`.
- Reset mid-roll: `Reset` for 1 cycle while `Roll`=1 and `nButton` is released →
  - Next edge: all outputs 0, state IDLE.
  - No `Settled` pulse afterwards.
